// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - pipelined Gray-to-binary decoder with step classification, error count and lock
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous active-low reset
//   in_valid    gray_in carries a sample this cycle
//   gray_in     Gray-coded sample, WIDTH bits
//   out_valid   one-cycle strobe, output fields updated this cycle
//   binary      decoded value of the sample (held while out_valid=0)
//   dir         1 = last legal step was +1, 0 = -1 (held across hold/error samples)
//   hold        strobe: sample equals the previous reference
//   step_error  strobe: sample differs from the reference in two or more bits
//   err_count   illegal-jump count, saturating at 255
//   locked      LOCK_RUN consecutive legal steps since the last error/reset
//
// Pipeline: input register, decode register, classify/output register.
// A sample presented at edge N is reported at edge N+2.

module gray_decoder #(
   parameter int WIDTH    = 3,
   parameter int LOCK_RUN = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] gray_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] binary,
   output logic             dir,
   output logic             hold,
   output logic             step_error,
   output logic [7:0]       err_count,
   output logic             locked
);

   localparam logic [3:0] LOCK_VAL = 4'(LOCK_RUN);

   typedef enum logic {
      EMPTY = 1'b0,
      TRACK = 1'b1
   } state_t;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // stage 1: raw input capture
   logic             s1_valid;
   logic [WIDTH-1:0] s1_gray;

   // stage 2: raw sample plus its decoded value
   logic             s2_valid;
   logic [WIDTH-1:0] s2_gray;
   logic [WIDTH-1:0] s2_bin;

   // tracking state
   state_t           state, state_n;
   logic [WIDTH-1:0] ref_gray, ref_gray_n;
   logic [WIDTH-1:0] ref_bin, ref_bin_n;
   logic [3:0]       run_cnt, run_cnt_n;

   // next values of the registered outputs
   logic             out_valid_n;
   logic [WIDTH-1:0] binary_n;
   logic             dir_n;
   logic             hold_n;
   logic             step_error_n;
   logic [7:0]       err_count_n;
   logic             locked_n;

   logic [WIDTH-1:0] diff;
   logic             diff_zero;
   logic             diff_onehot;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_gray  <= '0;
         s2_valid <= 1'b0;
         s2_gray  <= '0;
         s2_bin   <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_gray  <= gray_in;
         s2_valid <= s1_valid;
         s2_gray  <= s1_gray;
         s2_bin   <= gray2bin(s1_gray);
      end
   end

   // Distance classes only need 0 / 1 / >=2 differing bits, so a zero test
   // and a power-of-two test replace a full popcount.
   always_comb begin
      diff        = s2_gray ^ ref_gray;
      diff_zero   = (diff == '0);
      diff_onehot = !diff_zero && ((diff & (diff - WIDTH'(1))) == '0);
   end

   always_comb begin
      state_n      = state;
      ref_gray_n   = ref_gray;
      ref_bin_n    = ref_bin;
      run_cnt_n    = run_cnt;
      out_valid_n  = 1'b0;
      binary_n     = binary;
      dir_n        = dir;
      hold_n       = 1'b0;
      step_error_n = 1'b0;
      err_count_n  = err_count;
      locked_n     = locked;

      if (s2_valid) begin
         out_valid_n = 1'b1;
         binary_n    = s2_bin;
         // every sample becomes the new reference, so an illegal jump resyncs
         ref_gray_n  = s2_gray;
         ref_bin_n   = s2_bin;
         state_n     = TRACK;

         case (state)
            EMPTY: begin
               // first sample only establishes the reference
            end
            TRACK: begin
               if (diff_zero) begin
                  hold_n = 1'b1;
               end else if (diff_onehot) begin
                  // modular add makes 2^WIDTH-1 -> 0 count as an up step
                  dir_n = (s2_bin == ref_bin + WIDTH'(1));
                  if (run_cnt != LOCK_VAL) begin
                     run_cnt_n = run_cnt + 4'd1;
                  end
               end else begin
                  step_error_n = 1'b1;
                  run_cnt_n    = 4'd0;
                  if (err_count != 8'hFF) begin
                     err_count_n = err_count + 8'd1;
                  end
               end
            end
            default: begin
               state_n = EMPTY;
            end
         endcase

         locked_n = (run_cnt_n == LOCK_VAL);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= EMPTY;
         ref_gray   <= '0;
         ref_bin    <= '0;
         run_cnt    <= 4'd0;
         out_valid  <= 1'b0;
         binary     <= '0;
         dir        <= 1'b0;
         hold       <= 1'b0;
         step_error <= 1'b0;
         err_count  <= 8'd0;
         locked     <= 1'b0;
      end else begin
         state      <= state_n;
         ref_gray   <= ref_gray_n;
         ref_bin    <= ref_bin_n;
         run_cnt    <= run_cnt_n;
         out_valid  <= out_valid_n;
         binary     <= binary_n;
         dir        <= dir_n;
         hold       <= hold_n;
         step_error <= step_error_n;
         err_count  <= err_count_n;
         locked     <= locked_n;
      end
   end

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - self-checking bench for gray_decoder against a behavioural reference model

module tb_gray_decoder;

   localparam int W  = 3;
   localparam int LR = 4;
   localparam int M  = 1 << W;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] gray_in;
   logic         out_valid;
   logic [W-1:0] binary;
   logic         dir;
   logic         hold;
   logic         step_error;
   logic [7:0]   err_count;
   logic         locked;

   always #5 clk = ~clk;

   gray_decoder #(.WIDTH(W), .LOCK_RUN(LR)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .gray_in    (gray_in),
      .out_valid  (out_valid),
      .binary     (binary),
      .dir        (dir),
      .hold       (hold),
      .step_error (step_error),
      .err_count  (err_count),
      .locked     (locked)
   );

   int errors = 0;
   int checks = 0;

   // reference model state
   bit m_have;
   int m_ref, m_refbin, m_run, m_err;
   int e_valid, e_bin, e_dir, e_hold, e_serr, e_locked;
   bit q_v[2];
   int q_g[2];
   int cur_bin;

   function automatic int g2b(int g);
      int b = g;
      for (int s = 1; s < W; s++) b = b ^ (g >> s);
      return b;
   endfunction

   function automatic int b2g(int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_ref = 0; m_refbin = 0; m_run = 0; m_err = 0;
      e_valid = 0; e_bin = 0; e_dir = 0; e_hold = 0; e_serr = 0; e_locked = 0;
      q_v[0] = 0; q_v[1] = 0; q_g[0] = 0; q_g[1] = 0;
   endtask

   task automatic classify(int g);
      int bin;
      int d;
      bin = g2b(g);
      e_valid = 1;
      e_bin = bin;
      if (m_have) begin
         d = $countones(g ^ m_ref);
         if (d == 0) begin
            e_hold = 1;
         end else if (d == 1) begin
            e_dir = (bin == (m_refbin + 1) % M) ? 1 : 0;
            if (m_run < LR) m_run++;
         end else begin
            e_serr = 1;
            if (m_err < 255) m_err++;
            m_run = 0;
         end
      end
      m_have = 1;
      m_ref = g;
      m_refbin = bin;
      e_locked = (m_run == LR) ? 1 : 0;
   endtask

   // advance the model by one rising edge; samples are reported two edges later
   task automatic model_edge(bit rst_n, bit v, int g);
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_valid = 0; e_hold = 0; e_serr = 0;
      if (q_v[1]) classify(q_g[1]);
      q_v[1] = q_v[0]; q_g[1] = q_g[0];
      q_v[0] = v;      q_g[0] = g;
   endtask

   task automatic step(bit rst_n, bit v, int g);
      logic [31:0] gv;
      gv = g;
      reset    = rst_n;
      in_valid = v;
      gray_in  = gv[W-1:0];
      @(posedge clk);
      model_edge(rst_n, v, g);
      #1;
      check("out_valid",  out_valid,  e_valid);
      check("binary",     binary,     e_bin);
      check("dir",        dir,        e_dir);
      check("hold",       hold,       e_hold);
      check("step_error", step_error, e_serr);
      check("err_count",  err_count,  m_err);
      check("locked",     locked,     e_locked);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1, 0, 0);
   endtask

   initial begin
      int up_seq[9]   = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
      int down_seq[3] = '{0, 4, 5};
      int hg_seq[3]   = '{3, 3, 2};
      int r;
      model_reset();
      reset = 1'b0; in_valid = 1'b0; gray_in = '0;

      // reset held with in_valid=1
      for (int i = 0; i < 3; i++) step(0, 1, int'($urandom_range(0, M - 1)));
      check("reset_binary", binary, 0);
      check("reset_err", err_count, 0);

      // up count with wrap
      foreach (up_seq[i]) step(1, 1, up_seq[i]);
      idle(2);
      check("up_final_bin", binary, 0);
      check("up_locked", locked, 1);
      check("up_dir", dir, 1);
      check("up_err", err_count, 0);

      // down count across wrap
      foreach (down_seq[i]) step(1, 1, down_seq[i]);
      idle(2);
      check("down_bin", binary, 6);
      check("down_dir", dir, 0);

      // hold and gaps
      step(1, 1, hg_seq[0]);
      idle(3);
      step(1, 1, hg_seq[1]);
      step(1, 1, hg_seq[2]);
      idle(2);

      // lock, illegal jump, then legal up step
      for (int i = 0; i < 4; i++) step(1, 1, (i % 2 == 0) ? 3 : 2);
      step(1, 1, 5);
      step(1, 1, 4);
      idle(2);
      check("jump_bin", binary, 7);
      check("jump_locked", locked, 0);

      // error-count saturation
      for (int i = 0; i < 300; i++) step(1, 1, (i % 2 == 0) ? 0 : 3);
      idle(2);
      check("sat_err", err_count, 255);

      // mid-stream reset
      step(1, 1, 1);
      step(1, 1, 3);
      step(0, 1, 2);
      check("midrst_err", err_count, 0);
      check("midrst_valid", out_valid, 0);
      step(1, 1, 6);
      step(1, 1, 7);
      idle(2);

      // randomized mostly-legal walk with gaps and occasional jumps
      cur_bin = 0;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 11));
         if (r < 4)       cur_bin = (cur_bin + 1) % M;
         else if (r < 7)  cur_bin = (cur_bin + M - 1) % M;
         else if (r == 8) cur_bin = int'($urandom_range(0, M - 1));
         if (r == 9) step(1, 0, int'($urandom_range(0, M - 1)));
         else if (i == 200) step(0, 1, b2g(cur_bin));
         else step(1, 1, b2g(cur_bin));
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
